// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Round scheduler between the block-request interface and the key_expand /
//   cipher-round datapath. It accepts one request per in_valid/in_ready
//   handshake, re-expands the key when needed, steps the round index and
//   raises out_valid for a completion handshake.
//
//   Optional feature macro: AES_DECRYPT_EN (decrypt round ordering Nr..0).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (ready only while idle)
//   in_new_key          force key re-expansion
//   in_key_length       00/01=128, 10=192, 11=256
//   in_decrypt          decrypt request (AES_DECRYPT_EN builds only)
//   kx_change_key       key_expand load strobe
//   kx_key_length       key length sent with kx_change_key
//   kx_round            round index to key_expand (mirrors round counter)
//   kx_valid            key_expand schedule valid
//   kx_key_length_in    key length currently held by key_expand
//   dp_load             load state + AddRoundKey(round 0)
//   dp_round_en         execute one cipher round
//   dp_final            current round is the final one
//   out_valid/out_ready completion handshake
//   kx_error            sticky key_expand timeout flag
module aes_round_sequencer #(
    parameter int unsigned KX_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_new_key,
    input  logic [1:0] in_key_length,
    input  logic       in_decrypt,
    output logic       kx_change_key,
    output logic [1:0] kx_key_length,
    output logic [3:0] kx_round,
    input  logic       kx_valid,
    input  logic [1:0] kx_key_length_in,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_final,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       kx_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_REQ, S_KEY_WAIT, S_LOAD, S_ROUND, S_DONE
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = KX_TIMEOUT[7:0];

    state_t     r_state;
    logic [3:0] r_rnd;
    logic [1:0] r_len;
    logic [7:0] r_wait;
    logic       r_err;

    logic       w_dec;
    logic [3:0] w_nr;
    logic [3:0] w_start_in;
    logic [3:0] w_start_lat;
    logic [3:0] w_step;
    logic       w_last;

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            2'b10:   return 4'd12;
            2'b11:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

`ifdef AES_DECRYPT_EN
    logic r_dec;
    assign w_dec      = r_dec;
    // Decrypt starts from the last round key, so LOAD presents Nr.
    assign w_start_in = in_decrypt ? nr_of(in_key_length) : 4'd0;
`else
    logic w_unused_decrypt;
    assign w_unused_decrypt = in_decrypt;
    assign w_dec            = 1'b0;
    assign w_start_in       = 4'd0;
`endif

    assign w_nr        = nr_of(r_len);
    assign w_start_lat = w_dec ? w_nr : 4'd0;
    assign w_step      = w_dec ? (r_rnd - 4'd1) : (r_rnd + 4'd1);
    assign w_last      = w_dec ? (r_rnd == 4'd0) : (r_rnd == w_nr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rnd   <= '0;
            r_len   <= 2'b11;
            r_wait  <= '0;
            r_err   <= 1'b0;
`ifdef AES_DECRYPT_EN
            r_dec   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_len <= in_key_length;
`ifdef AES_DECRYPT_EN
                        r_dec <= in_decrypt;
`endif
                        if (in_new_key || (in_key_length != kx_key_length_in)) begin
                            r_state <= S_KEY_REQ;
                        end else begin
                            r_state <= S_LOAD;
                            r_rnd   <= w_start_in;
                        end
                    end
                end
                S_KEY_REQ: begin
                    // kx_change_key fires only while key_expand reports idle
                    if (kx_valid) begin
                        r_state <= S_KEY_WAIT;
                        r_wait  <= 8'd1;
                    end
                end
                S_KEY_WAIT: begin
                    // Cycle 1 is a guard: key_expand still shows the old valid.
                    if ((r_wait != 8'd1) && kx_valid) begin
                        r_state <= S_LOAD;
                        r_rnd   <= w_start_lat;
                    end else if (r_wait >= LP_TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_ROUND;
                    r_rnd   <= w_step;
                end
                S_ROUND: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_rnd <= w_step;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_rnd   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rnd   <= '0;
                end
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign kx_change_key = (r_state == S_KEY_REQ) && kx_valid;
    assign kx_key_length = (r_state == S_KEY_REQ) ? r_len : 2'b00;
    assign kx_round      = r_rnd;
    assign dp_load       = (r_state == S_LOAD);
    assign dp_round_en   = (r_state == S_ROUND);
    assign dp_final      = (r_state == S_ROUND) && w_last;
    assign out_valid     = (r_state == S_DONE);
    assign kx_error      = r_err;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

    localparam int unsigned KX = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_new_key, in_decrypt;
    logic [1:0] in_key_length;
    logic       kx_change_key;
    logic [1:0] kx_key_length;
    logic [3:0] kx_round;
    logic       kx_valid;
    logic [1:0] kx_key_length_in;
    logic       dp_load, dp_round_en, dp_final, out_valid, out_ready, kx_error;

    always #5 clk = ~clk;

    aes_round_sequencer #(.KX_TIMEOUT(KX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_new_key(in_new_key), .in_key_length(in_key_length), .in_decrypt(in_decrypt),
        .kx_change_key(kx_change_key), .kx_key_length(kx_key_length), .kx_round(kx_round),
        .kx_valid(kx_valid), .kx_key_length_in(kx_key_length_in),
        .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_final(dp_final),
        .out_valid(out_valid), .out_ready(out_ready), .kx_error(kx_error)
    );

    int errors = 0;
    int checks = 0;
    logic m_err;

    // key_expand emulation: valid stays high one cycle after a load strobe,
    // then drops for kx_D cycles; kx_pre models being busy before the strobe.
    int unsigned kx_pre, kx_cnt, kx_D;
    logic        kx_late;
    logic [1:0]  kx_pend;
    logic        prev_chg;
    logic [1:0]  prev_len;

    int cyc = 0, load_cyc = 0, lat = 0, n_rounds = 0, n_chg = 0;
    logic seen_ov;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] rl();
        return 2'($urandom_range(0, 3));
    endfunction

    // {in_ready, change, klen[1:0], round[3:0], load, round_en, final, out_valid, error}
    function automatic logic [12:0] ev(input logic rdy, input logic chg, input logic [1:0] len,
                                       input logic [3:0] rnd, input logic ld, input logic ren,
                                       input logic fin, input logic ov);
        return {rdy, chg, len, rnd, ld, ren, fin, ov, m_err};
    endfunction

    function automatic logic [12:0] ev_idle();
        return ev(1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [12:0] ev_zero();
        return ev(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [12:0] act_vec();
        return {in_ready, kx_change_key, kx_key_length, kx_round,
                dp_load, dp_round_en, dp_final, out_valid, kx_error};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic kx_reset();
        kx_pre = 0; kx_cnt = 0; kx_D = 0; kx_late = 1'b0; kx_pend = 2'b11;
        prev_chg = 1'b0; prev_len = 2'b00;
        kx_valid = 1'b1; kx_key_length_in = 2'b11;
    endtask

    task automatic kx_emulate();
        if (prev_chg) begin
            kx_late = 1'b1; kx_pend = prev_len; kx_valid = 1'b1;
        end else if (kx_late) begin
            kx_late = 1'b0;
            if (kx_D == 0) begin
                kx_valid = 1'b1; kx_key_length_in = kx_pend;
            end else begin
                kx_valid = 1'b0; kx_cnt = kx_D;
            end
        end else if (kx_cnt > 0) begin
            kx_cnt--;
            if (kx_cnt == 0) begin
                kx_valid = 1'b1; kx_key_length_in = kx_pend;
            end
        end else if (kx_pre > 0) begin
            kx_pre--; kx_valid = 1'b0;
        end else begin
            kx_valid = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] l, input logic nk, input logic d,
                        input logic ordy, input logic [12:0] exp, input logic chk_rnd);
        logic [12:0] act, m;
        @(negedge clk);
        cyc++;
        kx_emulate();
        in_valid = v; in_key_length = l; in_new_key = nk; in_decrypt = d; out_ready = ordy;
        #1;
        act = act_vec();
        m = chk_rnd ? 13'h1FFF : 13'h1E1F;
        checks++;
        if ((act & m) != (exp & m)) begin
            errors++;
            $display("FAIL cycle %0d outputs: got %013b expected %013b mask %013b",
                     cyc, act, exp, m);
        end
        if (dp_load) begin load_cyc = cyc; n_rounds = 0; seen_ov = 1'b0; end
        if (dp_round_en) n_rounds++;
        if (out_valid && !seen_ov) begin seen_ov = 1'b1; lat = cyc - load_cyc; end
        if (kx_change_key) n_chg++;
        prev_chg = kx_change_key; prev_len = kx_key_length;
    endtask

    task automatic junk(input logic [12:0] exp, input logic ordy, input logic chk_rnd);
        step(rb(), rl(), rb(), rb(), ordy, exp, chk_rnd);
    endtask

    task automatic async_reset();
        logic [12:0] act;
        #2;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        kx_reset();
        m_err = 1'b0;
        act = act_vec();
        check("async reset outputs", int'(act), int'(ev_idle()));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected trace of one block, derived from the request, the key_expand
    // busy/delay it will see, and how long the consumer stalls.
    task automatic run_block(input logic [1:0] len, input logic nk, input logic dec,
                             input int unsigned P, input int unsigned D, input int unsigned R,
                             input int unsigned gap, input int unsigned stop_i,
                             output logic timed_out);
        int unsigned nr;
        logic eff_dec, need;
        timed_out = 1'b0;
        n_chg = 0;
`ifdef AES_DECRYPT_EN
        eff_dec = dec;
`else
        eff_dec = 1'b0;
`endif
        nr = (len == 2'b10) ? 12 : (len == 2'b11) ? 14 : 10;
        for (int unsigned i = 0; i < gap; i++) step(1'b0, rl(), rb(), rb(), rb(), ev_idle(), 1'b1);
        step(1'b1, len, nk, dec, rb(), ev_idle(), 1'b1);
        need = nk || (len != kx_key_length_in);
        if (need) begin
            kx_pre = P; kx_D = D;
            for (int unsigned i = 0; i < P; i++)
                junk(ev(1'b0, 1'b0, len, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), rb(), 1'b1);
            junk(ev(1'b0, 1'b1, len, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), rb(), 1'b1);
            if (D + 2 > KX) begin
                for (int unsigned i = 0; i < KX; i++) junk(ev_zero(), rb(), 1'b1);
                m_err = 1'b1;
                timed_out = 1'b1;
                step(1'b0, rl(), rb(), rb(), rb(), ev_idle(), 1'b1);
                step(1'b0, rl(), rb(), rb(), rb(), ev_idle(), 1'b1);
                return;
            end
            for (int unsigned i = 0; i < D + 2; i++) junk(ev_zero(), rb(), 1'b1);
        end
        junk(ev(1'b0, 1'b0, 2'b00, eff_dec ? 4'(nr) : 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), rb(), 1'b1);
        for (int unsigned i = 1; i <= nr; i++) begin
            junk(ev(1'b0, 1'b0, 2'b00, eff_dec ? 4'(nr - i) : 4'(i), 1'b0, 1'b1, i == nr, 1'b0),
                 rb(), 1'b1);
            if (i == stop_i) begin
                async_reset();
                return;
            end
        end
        for (int unsigned i = 0; i < R; i++)
            junk(ev(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
        junk(ev(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
    endtask

    initial begin
        logic to;
        rst = 1'b1;
        in_valid = 1'b0; in_new_key = 1'b0; in_key_length = 2'b00; in_decrypt = 1'b0;
        out_ready = 1'b0;
        m_err = 1'b0; seen_ov = 1'b0;
        kx_reset();
        #3;
        check("reset outputs", int'(act_vec()), int'(ev_idle()));
        @(negedge clk);
        rst = 1'b0;

        // 256-bit, key already held: no re-expansion
        run_block(2'b11, 1'b0, 1'b0, 0, 0, 0, 1, 0, to);
        check("256 change_key count", n_chg, 0);
        check("256 round count", n_rounds, 14);
        check("256 load->out_valid", lat, 15);

        // 128-bit with new key, key_expand busy two cycles, three-cycle expansion
        run_block(2'b00, 1'b1, 1'b0, 2, 3, 0, 0, 0, to);
        check("128 change_key count", n_chg, 1);
        check("128 round count", n_rounds, 10);
        check("128 load->out_valid", lat, 11);

        // consumer stalls 5 cycles in DONE
        run_block(2'b00, 1'b0, 1'b0, 0, 0, 5, 1, 0, to);
        check("stall change_key count", n_chg, 0);
        check("stall load->out_valid", lat, 11);

        // key_expand never returns valid
        run_block(2'b01, 1'b1, 1'b0, 0, 40, 0, 0, 0, to);
        check("timeout flagged", int'(to), 1);
        check("kx_error sticky", int'(kx_error), 1);
        async_reset();

        // reset at 192-bit round 6, then a clean 192-bit block
        run_block(2'b10, 1'b1, 1'b0, 1, 2, 0, 0, 6, to);
        run_block(2'b10, 1'b0, 1'b0, 0, 1, 0, 1, 0, to);
        check("192 round count", n_rounds, 12);
        check("192 load->out_valid", lat, 13);

        // 192-bit decrypt request (round order depends on the build)
        run_block(2'b10, 1'b1, 1'b1, 0, 2, 1, 0, 0, to);
        check("192 dec round count", n_rounds, 12);

        // KEY_WAIT boundary: valid arriving in the last allowed cycle wins
        run_block(2'b11, 1'b1, 1'b0, 0, KX - 2, 0, 0, 0, to);
        check("last-cycle valid not timeout", int'(to), 0);

        for (int k = 0; k < 40; k++) begin
            int unsigned d;
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(KX - 3, KX) : $urandom_range(0, 6);
            run_block(rl(), ($urandom_range(0, 3) == 0), rb(), $urandom_range(0, 3), d,
                      $urandom_range(0, 3), $urandom_range(0, 2), 0, to);
            if (to) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
